// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with sync and
// blanking flags, packed onto the standard VGA bus, plus a frame-wrap pulse.
`timescale 1ns/1ps

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pix_en,
    output logic [`VGA_BUS_SIZE-1:0] vga_bus_out,
    output logic                     frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [11:0] RGB_BLACK  = 12'h000;

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vsync_q, vsync_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;
    logic        h_wrap, v_wrap;

    // Flags are decoded from the next counter values so that they land in the
    // same register stage as the counts they describe (zero skew on the bus).
    always_comb begin
        h_wrap        = (hcount_q == H_LAST);
        v_wrap        = (vcount_q == V_LAST);
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;

        if (pix_en) begin
            if (h_wrap) begin
                hcount_d = 11'd0;
                if (v_wrap) begin
                    vcount_d      = 11'd0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + 11'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end

        hblnk_d = (hcount_d >= H_VIS_END);
        hsync_d = (hcount_d >= H_SYNC_BEG) && (hcount_d <= H_SYNC_END);
        vblnk_d = (vcount_d >= V_VIS_END);
        vsync_d = (vcount_d >= V_SYNC_BEG) && (vcount_d <= V_SYNC_END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q      <= 11'd0;
            vcount_q      <= 11'd0;
            hsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vsync_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            hblnk_q       <= hblnk_d;
            vsync_q       <= vsync_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Bus-merge layout, MSB first: hcount, hsync, hblnk, vcount, vsync, vblnk, rgb.
    assign vga_bus_out = {hcount_q, hsync_q, hblnk_q, vcount_q, vsync_q, vblnk_q, RGB_BLACK};
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: one default-size instance and one scaled
// instance (24x12 raster) driven by the same clock, reset and pixel enable.
`timescale 1ns/1ps

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module tb_vga_timing_gen;

    logic                     clk    = 1'b0;
    logic                     rst    = 1'b0;
    logic                     pix_en = 1'b0;
    logic [`VGA_BUS_SIZE-1:0] bus_a, bus_b;
    logic                     fs_a, fs_b;

    int   n_checks = 0;
    int   n_errors = 0;
    int   a_h = 0, a_v = 0, b_h = 0, b_v = 0;
    logic a_fs_exp = 1'b0, b_fs_exp = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_a (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .vga_bus_out (bus_a),
        .frame_start (fs_a)
    );

    vga_timing_gen #(
        .H_VISIBLE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_VISIBLE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .vga_bus_out (bus_b),
        .frame_start (fs_b)
    );

    function automatic logic [`VGA_BUS_SIZE-1:0] mk_bus(input int h, input int v,
                                                         input int hvis, input int hss, input int hse,
                                                         input int vvis, input int vss, input int vse);
        logic hs, hb, vs, vb;
        hb = (h >= hvis);
        hs = (h >= hss) && (h <= hse);
        vb = (v >= vvis);
        vs = (v >= vss) && (v <= vse);
        return {11'(h), hs, hb, 11'(v), vs, vb, 12'h000};
    endfunction

    task automatic check(input string tag, input logic [`VGA_BUS_SIZE-1:0] obs,
                         input logic [`VGA_BUS_SIZE-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_a_bus"}, bus_a, mk_bus(a_h, a_v, 800, 840, 967, 600, 601, 604));
        check({tag, "_a_fs"}, 38'(fs_a), 38'(a_fs_exp));
        check({tag, "_b_bus"}, bus_b, mk_bus(b_h, b_v, 16, 18, 21, 8, 9, 10));
        check({tag, "_b_fs"}, 38'(fs_b), 38'(b_fs_exp));
    endtask

    // Raster position the bench expects after one clock edge.
    task automatic adv(inout int h, inout int v, output logic fs, input int ht, input int vt);
        fs = 1'b0;
        if (!rst) begin
            h = 0;
            v = 0;
        end else if (pix_en) begin
            if (h == ht - 1) begin
                h = 0;
                if (v == vt - 1) begin
                    v  = 0;
                    fs = 1'b1;
                end else begin
                    v++;
                end
            end else begin
                h++;
            end
        end
    endtask

    task automatic step(input logic pe, input string tag);
        pix_en = pe;
        @(posedge clk);
        #1;
        adv(a_h, a_v, a_fs_exp, 1056, 628);
        adv(b_h, b_v, b_fs_exp, 24, 12);
        check_all(tag);
    endtask

    initial begin
        logic [`VGA_BUS_SIZE-1:0] snap;

        // Held in reset, even with the enable high.
        step(1'b0, "reset0");
        step(1'b1, "reset1");
        step(1'b1, "reset2");

        // One full default line; scaled raster wraps several frames meanwhile.
        rst = 1'b1;
        for (int k = 1; k <= 1056; k++) begin
            step(1'b1, "line");
            snap = bus_a;
            if (k == 1)    check("a_first_h1", 38'(snap[37:27]), 38'(1));
            if (k == 799)  check("a_hblnk_799", 38'(snap[25]), 38'(0));
            if (k == 800)  check("a_hblnk_800", 38'(snap[25]), 38'(1));
            if (k == 839)  check("a_hsync_839", 38'(snap[26]), 38'(0));
            if (k == 840)  check("a_hsync_840", 38'(snap[26]), 38'(1));
            if (k == 967)  check("a_hsync_967", 38'(snap[26]), 38'(1));
            if (k == 968)  check("a_hsync_968", 38'(snap[26]), 38'(0));
            if (k == 1056) check("a_line_wrap", 38'({snap[37:27], snap[24:14]}), 38'({11'd0, 11'd1}));
        end

        // Enable toggling every clock.
        for (int k = 0; k < 600; k++) begin
            step((k % 2) == 0, "toggle");
        end

        // Park the scaled raster on its last pixel, stall, then release.
        for (int i = 0; i < 400 && !(b_h == 23 && b_v == 11); i++) begin
            step(1'b1, "seek");
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, "hold");
        end
        step(1'b1, "hold_release");
        snap = bus_b;
        check("b_wrap_pos", 38'({snap[37:27], snap[24:14]}), 38'(0));
        check("b_wrap_fs", 38'(fs_b), 38'(1));
        step(1'b1, "after_wrap");
        check("b_fs_single", 38'(fs_b), 38'(0));

        // Mid-line asynchronous reset.
        rst = 1'b0;
        step(1'b0, "rst_sync");
        rst = 1'b1;
        for (int i = 0; i < 500; i++) begin
            step(1'b1, "run500");
        end
        snap = bus_a;
        check("a_h500", 38'(snap[37:27]), 38'(500));
        #3;
        rst = 1'b0;
        a_h = 0; a_v = 0; b_h = 0; b_v = 0;
        a_fs_exp = 1'b0; b_fs_exp = 1'b0;
        #1;
        check_all("async_rst");
        step(1'b1, "held_rst");
        rst = 1'b1;
        step(1'b1, "restart");
        snap = bus_a;
        check("a_restart_h1", 38'(snap[37:27]), 38'(1));
        check("a_restart_fs", 38'(fs_a), 38'(0));
        step(1'b1, "restart2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 800, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 40, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 128, meaning hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 88, meaning horizontal back porch; H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (1056).
REQ-005 The block SHALL have parameter V_VISIBLE, default 600, meaning active lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 1, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 4, meaning vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 23, meaning vertical back porch; V_TOTAL = 628.
REQ-009 The block SHALL have port clk, input, 1, meaning the pixel-domain clock.
REQ-010 The block SHALL have port rst, input, 1, meaning the asynchronous, active-low reset.
REQ-011 The block SHALL have port pix_en, input, 1, meaning the pixel-advance enable (1 = advance one pixel this clk).
REQ-012 The block SHALL have port vga_bus_out, output, `VGA_BUS_SIZE, meaning the standard VGA bus carrying hcount, hsync, hblnk, vcount, vsync, vblnk and rgb, packed with the standard bus-merge layout.
REQ-013 The block SHALL have port frame_start, output, 1, meaning a one-clk pulse on each frame wrap.

Function
REQ-014 hcount and vcount SHALL be 11-bit registered counters carried on the bus; all bus fields SHALL be register outputs with no combinational path from pix_en.
REQ-015 On a clk edge with pix_en=1: if hcount = H_TOTAL-1, then hcount SHALL go to 0; otherwise hcount SHALL go to hcount+1.
REQ-016 On a clk edge with pix_en=1 and hcount = H_TOTAL-1: if vcount = V_TOTAL-1, then vcount SHALL go to 0; otherwise vcount SHALL go to vcount+1. Otherwise vcount SHALL hold.
REQ-017 With pix_en=0, every bus field SHALL hold its value.
REQ-018 hblnk SHALL be 1 exactly when hcount >= H_VISIBLE.
REQ-019 hsync SHALL be 1 (positive polarity) exactly when H_VISIBLE+H_FP <= hcount <= H_VISIBLE+H_FP+H_SYNC-1 (840..967).
REQ-020 vblnk SHALL be 1 exactly when vcount >= V_VISIBLE.
REQ-021 vsync SHALL be 1 exactly when V_VISIBLE+V_FP <= vcount <= V_VISIBLE+V_FP+V_SYNC-1 (601..604).
REQ-022 The flags in REQ-018 to REQ-021 SHALL be computed from the next counter values and registered in the same clk as the counters, so the flags are zero-skew with hcount/vcount on the bus.
REQ-023 The rgb field SHALL always be 12'h000; downstream overlay stages own colour.
REQ-024 frame_start SHALL be 1 for exactly one clk, registered in the same edge where (hcount,vcount) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0).
REQ-025 frame_start SHALL be 0 on every other clk, including while pix_en=0.
REQ-026 Counters SHALL never exceed H_TOTAL-1 / V_TOTAL-1; no intermediate out-of-range value SHALL appear on the bus.

Reset
REQ-027 While rst=0, all outputs SHALL be forced asynchronously to 0 (hcount=0, vcount=0, hsync=hblnk=vsync=vblnk=0, rgb=0, frame_start=0).
REQ-028 The first pix_en=1 edge after rst releases SHALL advance hcount to 1; the reset-time (0,0) position SHALL NOT raise frame_start.
REQ-029 Reset asserted mid-line or mid-frame SHALL abandon the frame immediately, with no completion of the line.

Verification
REQ-030 Release reset and hold pix_en=1 for 1056 clks -> hcount reads 0..1055 then 0; vcount is 1 at the wrap; hblnk rises at hcount=800; hsync is high for hcount 840..967 only.
REQ-031 Run a full frame (1056x628 = 663168 clks) -> vblnk rises at vcount=600; vsync is high for vcount 601..604; frame_start pulses once, coincident with (0,0); rgb is 0 throughout.
REQ-032 Toggle pix_en 1/0 every clk -> counters advance every second clk; flags stay aligned with counts; a frame wrap takes 1326336 clks.
REQ-033 Hold pix_en=0 at hcount=1055, vcount=627 for 10 clks, then assert it -> no wrap and no frame_start while held; wrap and a single frame_start pulse occur on the enabling edge.
REQ-034 Assert rst asynchronously at hcount=500, vcount=300 (between clk edges) -> all outputs are 0 before the next edge; after release the sequence restarts per REQ-028.
REQ-035 Override parameters to 16/2/4/2 and 8/1/2/1 -> H_TOTAL=24 and V_TOTAL=12; the checks of REQ-030 and REQ-031 hold with the scaled boundaries.
